// File: rtl/axis_blanker_pkg.sv
// Shared types and constants for the AXI4-Stream windowed blanker.
// Imported by axis_blanker and axis_blanker_ctrl.
package axis_blanker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    BLANK
  } state_e;

  localparam logic MODE_ZERO   = 1'b0;
  localparam logic MODE_HOLD   = 1'b1;
  localparam int   SYNC_STAGES = 2;

endpackage

// File: rtl/axis_blanker_ctrl.sv
// Trigger synchroniser, edge detect, window FSM and config capture.
// Reports blank_now plus the mode/lane enables latched at the trigger.
module axis_blanker_ctrl
  import axis_blanker_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 trig,
  input  logic                 beat,
  input  logic [CNT_WIDTH-1:0] cfg_delay,
  input  logic [CNT_WIDTH-1:0] cfg_length,
  input  logic                 cfg_mode,
  input  logic [NUM_LANES-1:0] cfg_lane_en,
  output logic                 busy,
  output logic                 blank_now,
  output logic                 mode,
  output logic [NUM_LANES-1:0] lane_en
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   trig_edge;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   len_q, len_d;
  logic                   mode_q, mode_d;
  logic [NUM_LANES-1:0]   lane_q, lane_d;
  logic                   busy_q;

  assign trig_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    lane_d  = lane_q;
    unique case (state_q)
      IDLE: begin
        if (trig_edge && cfg_length != '0) begin
          len_d  = cfg_length;
          mode_d = cfg_mode;
          lane_d = cfg_lane_en;
          if (cfg_delay == '0) begin
            state_d = BLANK;
            cnt_d   = cfg_length;
          end else begin
            state_d = DELAY;
            cnt_d   = cfg_delay;
          end
        end
      end
      DELAY: begin
        if (beat) begin
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d = BLANK;
            cnt_d   = len_q;
          end else begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end
        end
      end
      BLANK: begin
        if (beat) begin
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_ZERO;
      lane_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      lane_q  <= lane_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign busy      = busy_q;
  assign blank_now = (state_q == BLANK);
  assign mode      = mode_q;
  assign lane_en   = lane_q;

endmodule

// File: rtl/axis_blanker.sv
// Multi-lane AXI4-Stream blanker: lane datapath, hold regs, output slice.
// Optional blank_cnt statistics port under AXIS_BLANKER_STATS_EN.
module axis_blanker
  import axis_blanker_pkg::*;
#(
  parameter int LANE_WIDTH = 16,
  parameter int NUM_LANES  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            trig,
  input  logic [CNT_WIDTH-1:0]            cfg_delay,
  input  logic [CNT_WIDTH-1:0]            cfg_length,
  input  logic                            cfg_mode,
  input  logic [NUM_LANES-1:0]            cfg_lane_en,
  output logic                            busy,
  output logic                            s_axis_tready,
  input  logic [LANE_WIDTH*NUM_LANES-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [LANE_WIDTH*NUM_LANES-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid
`ifdef AXIS_BLANKER_STATS_EN
  ,
  output logic [31:0]                     blank_cnt
`endif
);

  localparam int DW = LANE_WIDTH * NUM_LANES;

  logic                 beat;
  logic                 blank_now;
  logic                 mode;
  logic [NUM_LANES-1:0] lane_en;

  logic [DW-1:0]        tdata_q;
  logic                 tvalid_q;
  logic [DW-1:0]        out_d;
  logic [DW-1:0]        hold_q, hold_d;

  assign s_axis_tready = !tvalid_q | m_axis_tready;
  assign beat          = s_axis_tvalid & s_axis_tready;

  axis_blanker_ctrl #(
    .NUM_LANES (NUM_LANES),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_ctrl (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .trig        (trig),
    .beat        (beat),
    .cfg_delay   (cfg_delay),
    .cfg_length  (cfg_length),
    .cfg_mode    (cfg_mode),
    .cfg_lane_en (cfg_lane_en),
    .busy        (busy),
    .blank_now   (blank_now),
    .mode        (mode),
    .lane_en     (lane_en)
  );

  // Hold tracks the last unblanked value of every lane, enabled or not.
  always_comb begin
    out_d  = s_axis_tdata;
    hold_d = hold_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (blank_now) begin
        if (lane_en[i]) begin
          out_d[i*LANE_WIDTH +: LANE_WIDTH] =
            (mode == MODE_HOLD) ? hold_q[i*LANE_WIDTH +: LANE_WIDTH]
                                : '0;
        end
      end else begin
        hold_d[i*LANE_WIDTH +: LANE_WIDTH] =
          s_axis_tdata[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      if (beat) begin
        tdata_q  <= out_d;
        tvalid_q <= 1'b1;
        hold_q   <= hold_d;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;

`ifdef AXIS_BLANKER_STATS_EN
  logic [31:0] blank_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      blank_cnt_q <= '0;
    end else if (beat && blank_now && !(&blank_cnt_q)) begin
      blank_cnt_q <= blank_cnt_q + 32'd1;
    end
  end

  assign blank_cnt = blank_cnt_q;
`endif

endmodule
